// File: rtl/route_sequencer.sv
// route_sequencer: mission FSM that hands motors to line-follow or overrides them for route turns, crossings and line search.
module route_sequencer #(
  parameter int          N_INT        = 4,
  parameter logic [24:0] DEBOUNCE     = 25'd50000,
  parameter logic [24:0] TURN_CYCLES  = 25'h0400000,
  parameter logic [24:0] LOST_TIMEOUT = 25'h0FFFFFF,
  parameter logic [7:0]  SPD_MAX      = 8'hBF,
  parameter logic [7:0]  SPD_HALF     = 8'h5F
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         sensors,
  input  logic [2*N_INT-1:0] route,
  output logic               lf_enable,
  output logic               sel,
  output logic [7:0]         speedL,
  output logic [7:0]         speedR,
  output logic               dirL,
  output logic               dirR,
  output logic [3:0]         int_idx,
  output logic               busy,
  output logic               done,
  output logic               fault
);
  typedef enum logic [3:0] {
    S_IDLE, S_FOLLOW, S_CONFIRM, S_CROSS, S_TURN_BLIND, S_TURN_SEEK, S_LOST, S_DONE, S_FAULT
  } state_t;
  state_t      r_state, w_next;
  logic [24:0] r_cnt, w_cnt;
  logic [3:0]  r_int_idx, w_idx;
  logic        r_turn_dir, w_turn;
  logic        r_last_side, w_last;
  logic [1:0]  w_entry;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_int_idx   <= '0;
      r_turn_dir  <= 1'b0;
      r_last_side <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt;
      r_int_idx   <= w_idx;
      r_turn_dir  <= w_turn;
      r_last_side <= w_last;
    end
  end
  always_comb begin
    w_entry = 2'b11;
    for (int i = 0; i < N_INT; i++)
      if (r_int_idx == 4'(i)) w_entry = route[2*i +: 2];
  end
  always_comb begin
    w_next = r_state;
    w_idx  = r_int_idx;
    w_turn = r_turn_dir;
    w_last = r_last_side;
    case (r_state)
      S_IDLE, S_DONE, S_FAULT: if (start) begin
        w_next = S_FOLLOW;
        w_idx  = '0;
      end
      S_FOLLOW: begin
        w_last = (sensors == 3'b011 || sensors == 3'b001) ? 1'b0 :
                 (sensors == 3'b110 || sensors == 3'b100) ? 1'b1 : r_last_side;
        w_next = (sensors == 3'b000) ? S_CONFIRM : (sensors == 3'b111) ? S_LOST : S_FOLLOW;
      end
      S_CONFIRM: begin
        if (sensors != 3'b000) w_next = S_FOLLOW;
        else if (r_cnt == DEBOUNCE - 25'd1) begin
          if (r_int_idx == 4'(N_INT)) w_next = S_DONE;
          else begin
            w_idx  = r_int_idx + 4'd1;
            w_next = (w_entry == 2'b00) ? S_CROSS : (w_entry == 2'b11) ? S_DONE : S_TURN_BLIND;
            w_turn = (w_entry == 2'b10) ? 1'b1 : (w_entry == 2'b01) ? 1'b0 : r_turn_dir;
          end
        end
      end
      S_CROSS:      if (r_cnt == TURN_CYCLES - 25'd1) w_next = S_FOLLOW;
      S_TURN_BLIND: if (r_cnt == TURN_CYCLES - 25'd1) w_next = S_TURN_SEEK;
      S_TURN_SEEK:
        w_next = !sensors[1] ? S_FOLLOW : (r_cnt == LOST_TIMEOUT - 25'd1) ? S_FAULT : S_TURN_SEEK;
      S_LOST:
        w_next = (sensors != 3'b111) ? S_FOLLOW : (r_cnt == LOST_TIMEOUT - 25'd1) ? S_FAULT : S_LOST;
      default: w_next = S_IDLE;
    endcase
    // the first 000 sample is already counted when CONFIRM is entered
    w_cnt = (w_next == r_state) ? r_cnt + 25'd1 :
            (w_next == S_CONFIRM) ? 25'd1 : 25'd0;
  end
  logic w_pivot, w_side;
  always_comb begin
    lf_enable = 1'b0;
    sel       = 1'b1;
    speedL    = 8'd0;
    speedR    = 8'd0;
    dirL      = 1'b1;
    dirR      = 1'b1;
    w_pivot   = r_state inside {S_TURN_BLIND, S_TURN_SEEK, S_LOST};
    w_side    = (r_state == S_LOST) ? r_last_side : r_turn_dir;
    if (r_state inside {S_FOLLOW, S_CONFIRM}) begin
      lf_enable = 1'b1;
      sel       = 1'b0;
    end
    if (r_state == S_CROSS) begin
      speedL = SPD_MAX;
      speedR = SPD_MAX;
    end
    if (w_pivot) begin
      speedL = SPD_HALF;
      speedR = SPD_HALF;
      dirL   = w_side;
      dirR   = ~w_side;
    end
  end
  assign int_idx = r_int_idx;
  assign busy    = !(r_state inside {S_IDLE, S_DONE, S_FAULT});
  assign done    = r_state == S_DONE;
  assign fault   = r_state == S_FAULT;
endmodule

// File: tb/tb_route_sequencer.sv
// tb_route_sequencer: directed scenario tests for route_sequencer with small timing parameters.
module tb_route_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] sensors = 3'b101;
  logic [3:0] route = 4'b0001;
  logic       lf_enable, sel, dirL, dirR, busy, done, fault;
  logic [7:0] speedL, speedR;
  logic [3:0] int_idx;
  int checks = 0;
  int errors = 0;
  route_sequencer #(
    .N_INT(2), .DEBOUNCE(25'd4), .TURN_CYCLES(25'd8), .LOST_TIMEOUT(25'd20),
    .SPD_MAX(8'hBF), .SPD_HALF(8'h5F)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sensors(sensors), .route(route),
    .lf_enable(lf_enable), .sel(sel), .speedL(speedL), .speedR(speedR),
    .dirL(dirL), .dirR(dirR), .int_idx(int_idx), .busy(busy), .done(done), .fault(fault)
  );
  always #5 clk = ~clk;
  function automatic logic [26:0] outs();
    return {lf_enable, sel, speedL, speedR, dirL, dirR, int_idx, busy, done, fault};
  endfunction
  function automatic logic [26:0] fol(logic [3:0] idx);
    return {1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, idx, 1'b1, 1'b0, 1'b0};
  endfunction
  function automatic logic [26:0] piv(logic right, logic [3:0] idx);
    return {1'b0, 1'b1, 8'h5F, 8'h5F, right, ~right, idx, 1'b1, 1'b0, 1'b0};
  endfunction
  function automatic logic [26:0] crs(logic [3:0] idx);
    return {1'b0, 1'b1, 8'hBF, 8'hBF, 1'b1, 1'b1, idx, 1'b1, 1'b0, 1'b0};
  endfunction
  function automatic logic [26:0] sts(logic [3:0] idx, logic d, logic f);
    return {1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, idx, 1'b0, d, f};
  endfunction
  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    checks++;
    if (outs() !== sts(4'd0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL reset got=%h exp=%h", outs(), sts(4'd0, 1'b0, 1'b0));
    end
    step(1);
    checks++;
    if (outs() !== sts(4'd0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL idle_hold got=%h exp=%h", outs(), sts(4'd0, 1'b0, 1'b0));
    end
  endtask
  task automatic test_start();
    route = 4'b0001;
    sensors = 3'b101;
    start = 1'b1;
    step(1);
    start = 1'b0;
    checks++;
    if (outs() !== fol(4'd0)) begin
      errors++;
      $display("FAIL start got=%h exp=%h", outs(), fol(4'd0));
    end
  endtask
  task automatic test_turn_left();
    sensors = 3'b000;
    step(3);
    checks++;
    if (outs() !== fol(4'd0)) begin
      errors++;
      $display("FAIL confirm_wait got=%h exp=%h", outs(), fol(4'd0));
    end
    step(1);
    checks++;
    if (outs() !== piv(1'b0, 4'd1)) begin
      errors++;
      $display("FAIL turn_blind got=%h exp=%h", outs(), piv(1'b0, 4'd1));
    end
    sensors = 3'b101;
    step(7);
    checks++;
    if (outs() !== piv(1'b0, 4'd1)) begin
      errors++;
      $display("FAIL blind_ignores got=%h exp=%h", outs(), piv(1'b0, 4'd1));
    end
    step(1);
    checks++;
    if (outs() !== piv(1'b0, 4'd1)) begin
      errors++;
      $display("FAIL turn_seek got=%h exp=%h", outs(), piv(1'b0, 4'd1));
    end
    step(1);
    checks++;
    if (outs() !== fol(4'd1)) begin
      errors++;
      $display("FAIL seek_exit got=%h exp=%h", outs(), fol(4'd1));
    end
  endtask
  task automatic test_cross();
    sensors = 3'b000;
    step(4);
    checks++;
    if (outs() !== crs(4'd2)) begin
      errors++;
      $display("FAIL cross got=%h exp=%h", outs(), crs(4'd2));
    end
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(6);
    checks++;
    if (outs() !== crs(4'd2)) begin
      errors++;
      $display("FAIL cross_hold got=%h exp=%h", outs(), crs(4'd2));
    end
    sensors = 3'b101;
    step(1);
    checks++;
    if (outs() !== fol(4'd2)) begin
      errors++;
      $display("FAIL cross_exit got=%h exp=%h", outs(), fol(4'd2));
    end
  endtask
  task automatic test_glitch();
    sensors = 3'b000;
    step(3);
    sensors = 3'b101;
    step(1);
    checks++;
    if (outs() !== fol(4'd2)) begin
      errors++;
      $display("FAIL glitch_a got=%h exp=%h", outs(), fol(4'd2));
    end
    sensors = 3'b000;
    step(3);
    checks++;
    if (outs() !== fol(4'd2)) begin
      errors++;
      $display("FAIL glitch_b got=%h exp=%h", outs(), fol(4'd2));
    end
    sensors = 3'b101;
    step(1);
  endtask
  task automatic test_saturate();
    sensors = 3'b000;
    step(4);
    checks++;
    if (outs() !== sts(4'd2, 1'b1, 1'b0)) begin
      errors++;
      $display("FAIL saturate got=%h exp=%h", outs(), sts(4'd2, 1'b1, 1'b0));
    end
    sensors = 3'b101;
    start = 1'b1;
    step(1);
    start = 1'b0;
    checks++;
    if (outs() !== fol(4'd0)) begin
      errors++;
      $display("FAIL restart_done got=%h exp=%h", outs(), fol(4'd0));
    end
  endtask
  task automatic test_lost_fault();
    sensors = 3'b011;
    step(1);
    sensors = 3'b111;
    step(20);
    checks++;
    if (outs() !== piv(1'b0, 4'd0)) begin
      errors++;
      $display("FAIL lost_search got=%h exp=%h", outs(), piv(1'b0, 4'd0));
    end
    step(1);
    checks++;
    if (outs() !== sts(4'd0, 1'b0, 1'b1)) begin
      errors++;
      $display("FAIL lost_fault got=%h exp=%h", outs(), sts(4'd0, 1'b0, 1'b1));
    end
    step(4);
    checks++;
    if (outs() !== sts(4'd0, 1'b0, 1'b1)) begin
      errors++;
      $display("FAIL fault_hold got=%h exp=%h", outs(), sts(4'd0, 1'b0, 1'b1));
    end
    sensors = 3'b101;
    start = 1'b1;
    step(1);
    start = 1'b0;
    checks++;
    if (outs() !== fol(4'd0)) begin
      errors++;
      $display("FAIL fault_restart got=%h exp=%h", outs(), fol(4'd0));
    end
  endtask
  task automatic test_lost_right();
    sensors = 3'b110;
    step(1);
    sensors = 3'b111;
    step(1);
    checks++;
    if (outs() !== piv(1'b1, 4'd0)) begin
      errors++;
      $display("FAIL lost_right got=%h exp=%h", outs(), piv(1'b1, 4'd0));
    end
    sensors = 3'b101;
    step(1);
    checks++;
    if (outs() !== fol(4'd0)) begin
      errors++;
      $display("FAIL lost_recover got=%h exp=%h", outs(), fol(4'd0));
    end
  endtask
  task automatic test_done();
    route = 4'b1100;
    sensors = 3'b000;
    step(4);
    checks++;
    if (outs() !== crs(4'd1)) begin
      errors++;
      $display("FAIL done_cross got=%h exp=%h", outs(), crs(4'd1));
    end
    sensors = 3'b101;
    step(8);
    sensors = 3'b000;
    step(4);
    checks++;
    if (outs() !== sts(4'd2, 1'b1, 1'b0)) begin
      errors++;
      $display("FAIL done_stop got=%h exp=%h", outs(), sts(4'd2, 1'b1, 1'b0));
    end
  endtask
  task automatic test_reset_mid();
    route = 4'b0010;
    sensors = 3'b000;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(4);
    checks++;
    if (outs() !== piv(1'b1, 4'd1)) begin
      errors++;
      $display("FAIL turn_right got=%h exp=%h", outs(), piv(1'b1, 4'd1));
    end
    step(2);
    rst = 1'b1;
    step(1);
    checks++;
    if (outs() !== sts(4'd0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL reset_mid got=%h exp=%h", outs(), sts(4'd0, 1'b0, 1'b0));
    end
    rst = 1'b0;
    sensors = 3'b101;
    step(1);
  endtask
  initial begin
    test_reset();
    test_start();
    test_turn_left();
    test_cross();
    test_glitch();
    test_saturate();
    test_lost_fault();
    test_lost_right();
    test_done();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
